// File: rtl/uart_boot_loader.sv
// UART 8N1 receiver feeding a text-line parser: each "@AAAAAAAA DDDDDDDD" line
// becomes one 32-bit write on a valid/ready port; "//" comments and blank lines are skipped.
module uart_boot_loader #(
    parameter int CLK_FREQ = 80_000_000,
    parameter int BAUD     = 921_600
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rxd,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [15:0] o_word_count,
    output logic        o_frame_err,
    output logic        o_parse_err,
    output logic        o_overrun
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        LINE_START, SLASH, SKIP, ADDR, SEP, DATA, TAIL, WRITE, ERR
    } parse_state_t;

    rx_state_t    rx_state;
    parse_state_t ps;

    logic          rxd_meta, rxd_sync, rxd_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          hold_full;
    logic [7:0]    hold_byte;

    logic [31:0] addr_sh, data_sh;
    logic [3:0]  digits;
    logic        err_on_eol;

    logic       consume, is_hex, is_ws, is_eol, is_cr;
    logic [3:0] nib;

    // The parser pulls a byte every cycle it is not stalled; ERR is a single
    // bookkeeping cycle that leaves the held byte for the state it hands over to.
    assign consume = hold_full && (ps != WRITE) && (ps != ERR);
    assign is_ws   = (hold_byte == 8'h20) || (hold_byte == 8'h09);
    assign is_eol  = (hold_byte == 8'h0A);
    assign is_cr   = (hold_byte == 8'h0D);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (hold_byte >= "0" && hold_byte <= "9")      nib = 4'(hold_byte - 8'h30);
        else if (hold_byte >= "a" && hold_byte <= "f") nib = 4'(hold_byte - 8'h57);
        else if (hold_byte >= "A" && hold_byte <= "F") nib = 4'(hold_byte - 8'h37);
        else                                           is_hex = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            rxd_prev    <= 1'b1;
            rx_state    <= RX_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            hold_full   <= 1'b0;
            hold_byte   <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rxd_meta    <= i_uart_rxd;
            rxd_sync    <= rxd_meta;
            rxd_prev    <= rxd_sync;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            if (consume) hold_full <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (rxd_prev && !rxd_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == CW'(HALF - 1)) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == CW'(DIV - 1)) begin
                        baud_cnt <= '0;
                        shift    <= {rxd_sync, shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == CW'(DIV - 1)) begin
                        rx_state <= RX_IDLE;
                        if (!rxd_sync) begin
                            o_frame_err <= 1'b1;
                        end else if (hold_full && !consume) begin
                            o_overrun <= 1'b1;
                        end else begin
                            hold_byte <= shift;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ps           <= LINE_START;
            addr_sh      <= '0;
            data_sh      <= '0;
            digits       <= '0;
            err_on_eol   <= 1'b0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_word_count <= '0;
            o_parse_err  <= 1'b0;
        end else begin
            o_parse_err <= 1'b0;
            case (ps)
                WRITE: if (i_wr_ready) begin
                    o_wr_valid <= 1'b0;
                    if (o_word_count != 16'hFFFF) o_word_count <= o_word_count + 1'b1;
                    ps <= LINE_START;
                end
                ERR: ps <= err_on_eol ? LINE_START : SKIP;
                default: if (consume && !is_cr) begin
                    case (ps)
                        LINE_START:
                            if (hold_byte == "@") begin ps <= ADDR; digits <= '0; end
                            else if (hold_byte == "/") ps <= SLASH;
                            else if (!(is_eol || is_ws)) begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= 1'b0; end
                        SLASH:
                            if (hold_byte == "/") ps <= SKIP;
                            else begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= is_eol; end
                        SKIP:
                            if (is_eol) ps <= LINE_START;
                        ADDR:
                            if (is_hex) begin
                                addr_sh <= {addr_sh[27:0], nib};
                                digits  <= digits + 1'b1;
                                if (digits == 4'd7) ps <= SEP;
                            end else begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= is_eol; end
                        SEP:
                            if (is_hex) begin
                                data_sh <= {data_sh[27:0], nib};
                                digits  <= 4'd1;
                                ps      <= DATA;
                            end else if (!is_ws) begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= is_eol; end
                        DATA:
                            if (is_hex) begin
                                data_sh <= {data_sh[27:0], nib};
                                digits  <= digits + 1'b1;
                                if (digits == 4'd7) ps <= TAIL;
                            end else begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= is_eol; end
                        TAIL:
                            if (is_eol) begin
                                ps         <= WRITE;
                                o_wr_valid <= 1'b1;
                                o_wr_addr  <= addr_sh;
                                o_wr_data  <= data_sh;
                            end else if (!is_ws) begin ps <= ERR; o_parse_err <= 1'b1; err_on_eol <= 1'b0; end
                        default: ps <= LINE_START;
                    endcase
                end
            endcase
        end
    end
endmodule
